instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of control_unit and supplies its IRoutput word.
- Owns the fetch PC and issues word reads to instruction memory over a ready handshake.
- Holds up to two prefetched instructions in a small buffer.
- The control unit pops instructions with ir_ack and redirects fetch with pc_load on branches and jumps.

Parameters:
ADDR_W, 9, word-address width of instruction memory and PC
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
stop  input  1  when high, no new memory request is issued
mem_addr  output  ADDR_W  instruction memory word address
mem_rd  output  1  read request, held until mem_ready
mem_rdata  input  DATA_W  read data, valid when mem_ready=1
mem_ready  input  1  memory completes the current read this cycle
IRoutput  output  DATA_W  buffer head instruction, to control_unit
ir_valid  output  1  IRoutput holds a valid instruction
ir_ack  input  1  control unit consumes the head instruction this cycle
ir_pc  output  ADDR_W  address of the head instruction plus 1 (SRC PC semantics)
pc_load  input  1  redirect fetch and flush the buffer
pc_in  input  ADDR_W  redirect target address
busy  output  1  a read is outstanding (state FETCH or DISCARD)

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, buffer empty, state=IDLE.
  - mem_rd=0, mem_addr=RESET_PC, ir_valid=0, IRoutput=0, ir_pc=0, busy=0.
- FSM states: IDLE, FETCH, DISCARD.
  - IDLE -> FETCH when stop=0, count<2 and pc_load=0. Next cycle mem_rd=1 and mem_addr=pc.
  - FETCH:
    - mem_rd=1; mem_addr stays stable.
    - On mem_ready=1: push {mem_rdata, pc+1} into the buffer and set pc<=pc+1, wrapping mod 2^ADDR_W.
    - Then go to FETCH again if stop=0 and post-update count<2, else IDLE. Back-to-back reads give 1 word/cycle with zero-wait memory.
  - FETCH with pc_load=1 and mem_ready=0: pc<=pc_in, buffer flushed, go to DISCARD. mem_rd stays high; the handshake is never abandoned.
  - FETCH with pc_load=1 and mem_ready=1 in the same cycle: the returned word is dropped, pc<=pc_in, buffer flushed, go to IDLE.
  - DISCARD: mem_rd=1 at the old address until mem_ready=1. The data is dropped and the FSM goes to IDLE. A further pc_load in DISCARD only updates pc.
- Buffer:
  - 2-entry FIFO; count in 0..2.
  - ir_valid = count!=0. IRoutput and ir_pc come from the head entry and are registered values, not a combinational path from mem_rdata.
  - Fill latency: first instruction is visible the cycle after the mem_ready cycle.
  - ir_ack while ir_valid=1: pop. ir_ack while ir_valid=0 is ignored.
  - Push and pop in the same cycle: count unchanged, FIFO order kept.
  - Overflow is impossible: a read is issued only when count<2, and at most one read is outstanding.
- pc_load priority:
  - pc_load beats ir_ack and any push in the same cycle. The buffer becomes empty and ir_valid=0 on the next cycle.
  - pc_load in IDLE: pc<=pc_in, flush, stay IDLE that cycle.
- stop=1 blocks issue only. An outstanding read completes normally and its data is kept.
- Reset asserted mid-FETCH: mem_rd drops immediately (asynchronous). The memory is required to tolerate an abandoned request on reset only.

Decomposition:
- Shared package (cpu_pkg):
  - FSM state encoding constants IF_IDLE, IF_FETCH, IF_DISCARD.
  - ADDR_W and DATA_W defaults shared with control_unit and the memory.
- One sub-module, fetch_buffer: 2-entry FIFO with push, pop, flush, count, and head data/pc outputs.
- FSM and PC logic live in instr_fetch_unit.

Test Plan:
1. Reset release, zero-wait memory returning word 0x10000000 at addr 0 and 0x30000000 at addr 1, no ir_ack -> mem_rd asserted, two reads issued, then IDLE. IRoutput=0x10000000, ir_pc=1, ir_valid=1, mem_rd=0.
2. Scenario 1 state, then ir_ack on two consecutive cycles -> IRoutput 0x10000000 then 0x30000000. A refill read of addr 2 is issued once count<2.
3. Memory with 3 wait states and pc_load=1, pc_in=0x40 on the second wait cycle -> mem_addr stays at old address until mem_ready, data dropped, ir_valid=0. Next read at mem_addr=0x40, ir_pc=0x41.
4. pc_load and mem_ready in the same cycle -> returned word never appears on IRoutput. State IDLE, next request at pc_in.
5. pc=0x1FF (ADDR_W=9), fetch one word -> pc wraps to 0x000, ir_pc=0x000.
6. stop=1 raised during FETCH -> outstanding read completes and is buffered, no further mem_rd. Clear stop -> fetching resumes at the next PC. Then assert reset=0 mid-FETCH -> mem_rd=0 immediately, and on release pc=RESET_PC with ir_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths used by fetch, control and memory, and the
// fetch FSM state encoding.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 9;
  localparam int unsigned CPU_DATA_W = 32;

  localparam logic [1:0] IF_IDLE    = 2'd0;
  localparam logic [1:0] IF_FETCH   = 2'd1;
  localparam logic [1:0] IF_DISCARD = 2'd2;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry prefetch FIFO holding {instruction, pc+1}; flush wins over push/pop.
module fetch_buffer #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_pc
);

  logic [DATA_W-1:0] data_q [2];
  logic [ADDR_W-1:0] pc_q   [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              pop_en;
  logic              push_en;

  assign pop_en  = pop && (count_q != 2'd0);
  assign push_en = push && ((count_q != 2'd2) || pop_en);

  always_comb begin
    count_d = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + 2'd1;
    end else if (pop_en && !push_en) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      pc_q[0]   <= '0;
      pc_q[1]   <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_en) begin
        data_q[wr_ptr_q] <= push_data;
        pc_q[wr_ptr_q]   <= push_pc;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Head is forced to zero when empty so stale slots never leak to the decoder.
  assign count     = count_q;
  assign head_data = (count_q != 2'd0) ? data_q[rd_ptr_q] : '0;
  assign head_pc   = (count_q != 2'd0) ? pc_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs the memory read handshake and
// feeds a two-entry prefetch buffer consumed by the control unit.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned      ADDR_W   = CPU_ADDR_W,
  parameter int unsigned      DATA_W   = CPU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] IRoutput,
  output logic              ir_valid,
  input  logic              ir_ack,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              busy
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        count;
  logic [1:0]        post_count;
  logic              ack_pop;
  logic              buf_push;

  assign pc_inc     = pc_q + ADDR_W'(1);
  assign ack_pop    = ir_ack && ir_valid;
  // Occupancy after this cycle's push, used to decide a back-to-back read.
  assign post_count = count + 2'd1 - {1'b0, ack_pop};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_push = 1'b0;
    case (state_q)
      IF_IDLE: begin
        if (pc_load) begin
          pc_d = pc_in;
        end else if (!stop && (count < 2'd2)) begin
          state_d = IF_FETCH;
        end
      end
      IF_FETCH: begin
        if (pc_load) begin
          pc_d    = pc_in;
          state_d = mem_ready ? IF_IDLE : IF_DISCARD;
        end else if (mem_ready) begin
          buf_push = 1'b1;
          pc_d     = pc_inc;
          state_d  = (!stop && (post_count < 2'd2)) ? IF_FETCH : IF_IDLE;
        end
      end
      IF_DISCARD: begin
        if (pc_load) begin
          pc_d = pc_in;
        end
        if (mem_ready) begin
          state_d = IF_IDLE;
        end
      end
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IF_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      // Latch the in-flight address so a redirect cannot move it mid-handshake.
      if (state_q == IF_FETCH) begin
        addr_q <= pc_q;
      end
    end
  end

  assign mem_rd   = (state_q != IF_IDLE);
  assign busy     = mem_rd;
  assign mem_addr = (state_q == IF_DISCARD) ? addr_q : pc_q;
  assign ir_valid = (count != 2'd0);

  fetch_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fetch_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (buf_push),
    .push_data (mem_rdata),
    .push_pc   (pc_inc),
    .pop       (ack_pop),
    .flush     (pc_load),
    .count     (count),
    .head_data (IRoutput),
    .head_pc   (ir_pc)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a
// queue-based model of the fetch stage and a wait-state memory responder.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stop;
  logic [8:0]  mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] IRoutput;
  logic        ir_valid;
  logic        ir_ack;
  logic [8:0]  ir_pc;
  logic        pc_load;
  logic [8:0]  pc_in;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [512];
  int          mem_waits;
  int          wait_cnt;
  int          reads_done;
  bit          rand_waits;

  // Reference model: outstanding request tracking plus a queue of fetched words.
  logic [8:0]  m_pc;
  logic [8:0]  m_addr;
  bit          m_req;
  bit          m_drop;
  logic [31:0] m_qd[$];
  logic [8:0]  m_qp[$];

  instr_fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stop      (stop),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .IRoutput  (IRoutput),
    .ir_valid  (ir_valid),
    .ir_ack    (ir_ack),
    .ir_pc     (ir_pc),
    .pc_load   (pc_load),
    .pc_in     (pc_in),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] exp_addr();
    return m_req ? m_addr : m_pc;
  endfunction

  function automatic logic [31:0] exp_ir();
    return (m_qd.size() != 0) ? m_qd[0] : 32'h0;
  endfunction

  function automatic logic [8:0] exp_irpc();
    return (m_qp.size() != 0) ? m_qp[0] : 9'h0;
  endfunction

  task automatic model_reset();
    m_pc = 9'h0; m_addr = 9'h0; m_req = 0; m_drop = 0;
    m_qd.delete(); m_qp.delete();
  endtask

  task automatic model_clock();
    int sz;
    bit pop;
    sz  = m_qd.size();
    pop = ir_ack && (sz > 0);
    if (m_req && !m_drop) begin
      if (pc_load) begin
        m_pc = pc_in; m_qd.delete(); m_qp.delete();
        if (mem_ready) m_req = 0; else m_drop = 1;
      end else if (mem_ready) begin
        if (pop) begin void'(m_qd.pop_front()); void'(m_qp.pop_front()); end
        m_qd.push_back(mem_rdata);
        m_qp.push_back(m_pc + 9'd1);
        m_pc = m_pc + 9'd1;
        if (!stop && m_qd.size() < 2) m_addr = m_pc; else m_req = 0;
      end else if (pop) begin
        void'(m_qd.pop_front()); void'(m_qp.pop_front());
      end
    end else if (m_req) begin
      if (pc_load) begin m_pc = pc_in; m_qd.delete(); m_qp.delete(); end
      if (mem_ready) begin m_req = 0; m_drop = 0; end
    end else begin
      if (pc_load) begin
        m_pc = pc_in; m_qd.delete(); m_qp.delete();
      end else begin
        if (pop) begin void'(m_qd.pop_front()); void'(m_qp.pop_front()); end
        if (!stop && sz < 2) begin m_req = 1; m_addr = m_pc; end
      end
    end
  endtask

  // One clock: memory responds, clock edge, model advances, pulses cleared.
  task automatic step();
    if (mem_rd) begin
      if (wait_cnt >= mem_waits) begin
        mem_ready = 1'b1; mem_rdata = mem[mem_addr]; wait_cnt = 0; reads_done++;
        if (rand_waits) mem_waits = $urandom_range(0, 3);
      end else begin
        mem_ready = 1'b0; mem_rdata = $urandom; wait_cnt++;
      end
    end else begin
      mem_ready = 1'b0; mem_rdata = $urandom;
    end
    @(posedge clk);
    model_clock();
    @(negedge clk);
    ir_ack  = 1'b0;
    pc_load = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0; stop = 1'b0; ir_ack = 1'b0; pc_load = 1'b0; pc_in = 9'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    model_reset();
    wait_cnt = 0; reads_done = 0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
    checks++; if (mem_addr !== 9'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 000", mem_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %b want 0", ir_valid); end
    checks++; if (IRoutput !== 32'h0) begin errors++; $display("FAIL reset_IRoutput got %h want 0", IRoutput); end
    checks++; if (ir_pc !== 9'h0) begin errors++; $display("FAIL reset_ir_pc got %h want 000", ir_pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    apply_reset();
  endtask

  task automatic test_fill();
    apply_reset();
    mem[0] = 32'h1000_0000; mem[1] = 32'h3000_0000; mem_waits = 0;
    for (int i = 0; i < 10 && !(reads_done >= 2 && !mem_rd); i++) step();
    checks++; if (reads_done !== 2) begin errors++; $display("FAIL fill_reads got %0d want 2", reads_done); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL fill_mem_rd got %b want 0", mem_rd); end
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL fill_valid got %b want 1", ir_valid); end
    checks++; if (IRoutput !== 32'h1000_0000) begin errors++; $display("FAIL fill_IR got %h want 10000000", IRoutput); end
    checks++; if (ir_pc !== 9'h1) begin errors++; $display("FAIL fill_ir_pc got %h want 001", ir_pc); end
  endtask

  task automatic test_drain();
    ir_ack = 1'b1; step();
    checks++; if (IRoutput !== 32'h3000_0000) begin errors++; $display("FAIL drain_IR got %h want 30000000", IRoutput); end
    checks++; if (ir_pc !== 9'h2) begin errors++; $display("FAIL drain_ir_pc got %h want 002", ir_pc); end
    ir_ack = 1'b1; step();
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", ir_valid); end
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL refill_rd got %b want 1", mem_rd); end
    checks++; if (mem_addr !== 9'h2) begin errors++; $display("FAIL refill_addr got %h want 002", mem_addr); end
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    mem_waits = 3; mem[9'h40] = 32'hA5A5_0040;
    step();
    step();
    pc_load = 1'b1; pc_in = 9'h40; step();
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL discard_rd got %b want 1", mem_rd); end
    checks++; if (mem_addr !== 9'h0) begin errors++; $display("FAIL discard_addr got %h want 000", mem_addr); end
    step();
    step();
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL discard_idle_rd got %b want 0", mem_rd); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL discard_valid got %b want 0", ir_valid); end
    step();
    checks++; if (mem_addr !== 9'h40) begin errors++; $display("FAIL redirect_addr got %h want 040", mem_addr); end
    for (int i = 0; i < 10 && !ir_valid; i++) step();
    checks++; if (ir_pc !== 9'h41) begin errors++; $display("FAIL redirect_ir_pc got %h want 041", ir_pc); end
    checks++; if (IRoutput !== 32'hA5A5_0040) begin errors++; $display("FAIL redirect_IR got %h want a5a50040", IRoutput); end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    mem_waits = 0; mem[0] = 32'hDEAD_0000; mem[9'h80] = 32'h0BAD_F00D;
    step();
    pc_load = 1'b1; pc_in = 9'h80; step();
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL same_valid got %b want 0", ir_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_busy got %b want 0", busy); end
    step();
    checks++; if (mem_addr !== 9'h80) begin errors++; $display("FAIL same_addr got %h want 080", mem_addr); end
    step();
    checks++; if (IRoutput !== 32'h0BAD_F00D) begin errors++; $display("FAIL same_IR got %h want 0badf00d", IRoutput); end
  endtask

  task automatic test_wrap();
    apply_reset();
    mem_waits = 0; mem[9'h1FF] = 32'h1FF0_1FF0;
    pc_load = 1'b1; pc_in = 9'h1FF; step();
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL wrap_idle got %b want 0", mem_rd); end
    step();
    checks++; if (mem_addr !== 9'h1FF) begin errors++; $display("FAIL wrap_req_addr got %h want 1ff", mem_addr); end
    step();
    checks++; if (ir_pc !== 9'h0) begin errors++; $display("FAIL wrap_ir_pc got %h want 000", ir_pc); end
    checks++; if (IRoutput !== 32'h1FF0_1FF0) begin errors++; $display("FAIL wrap_IR got %h want 1ff01ff0", IRoutput); end
    checks++; if (mem_addr !== 9'h0) begin errors++; $display("FAIL wrap_pc got %h want 000", mem_addr); end
  endtask

  task automatic test_stop_reset();
    apply_reset();
    mem_waits = 2; mem[0] = 32'h5700_0000;
    step();
    stop = 1'b1;
    repeat (3) step();
    checks++; if (IRoutput !== 32'h5700_0000) begin errors++; $display("FAIL stop_kept got %h want 57000000", IRoutput); end
    repeat (3) step();
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL stop_blocks got %b want 0", mem_rd); end
    stop = 1'b0; step();
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 9'h1) begin
      errors++; $display("FAIL resume got rd=%b addr=%h want rd=1 addr=001", mem_rd, mem_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL async_reset_rd got %b want 0", mem_rd); end
    @(negedge clk);
    model_reset(); wait_cnt = 0;
    reset = 1'b1;
    checks++; if (ir_valid !== 1'b0 || mem_addr !== 9'h0) begin
      errors++; $display("FAIL post_reset got valid=%b addr=%h want valid=0 addr=000", ir_valid, mem_addr);
    end
    step();
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 9'h0) begin
      errors++; $display("FAIL post_reset_fetch got rd=%b addr=%h want rd=1 addr=000", mem_rd, mem_addr);
    end
  endtask

  task automatic test_random();
    apply_reset();
    rand_waits = 1; mem_waits = $urandom_range(0, 3);
    for (int i = 0; i < 400; i++) begin
      stop    = ($urandom_range(0, 9) == 0);
      ir_ack  = $urandom_range(0, 1);
      pc_load = ($urandom_range(0, 11) == 0);
      pc_in   = 9'($urandom);
      step();
      checks++; if (mem_rd !== m_req || busy !== m_req) begin
        errors++; $display("FAIL rnd_rd cyc %0d got rd=%b busy=%b want %b", i, mem_rd, busy, m_req);
      end
      checks++; if (mem_addr !== exp_addr()) begin
        errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", i, mem_addr, exp_addr());
      end
      checks++; if (ir_valid !== (m_qd.size() != 0)) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, ir_valid, m_qd.size() != 0);
      end
      checks++; if (IRoutput !== exp_ir() || ir_pc !== exp_irpc()) begin
        errors++; $display("FAIL rnd_head cyc %0d got %h/%h want %h/%h", i, IRoutput, ir_pc,
                           exp_ir(), exp_irpc());
      end
    end
    rand_waits = 0;
  endtask

  initial begin
    reset = 1'b0; stop = 1'b0; ir_ack = 1'b0; pc_load = 1'b0; pc_in = 9'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0; rand_waits = 0; mem_waits = 0;
    wait_cnt = 0; reads_done = 0;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_redirect_wait();
    test_same_cycle();
    test_wrap();
    test_stop_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
